pause_pc_stall_controller: RTL and testbench

PAUSE_PC_STALL_CONTROLLER -- requirements
Module: pause_pc_stall_controller

---
 rtl/pause_pc_stall_controller.sv | 82 ++++++++
 tb/tb_pause_pc_stall_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pause_pc_stall_controller.sv
// Fetch PC generator with stall hold and a one-deep redirect latch.
// A redirect that arrives while stalled is kept until the first stall-free cycle.
module pause_pc_stall_controller #(
  parameter int unsigned       DATA_SIZE    = 32,
  parameter int unsigned       NUM_STALL    = 2,
  parameter logic [DATA_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned       PC_STEP      = 4,
  parameter int unsigned       CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_STALL-1:0] stall_req,
  input  logic                 redirect_valid,
  input  logic [DATA_SIZE-1:0] redirect_pc,
  output logic [DATA_SIZE-1:0] pc_data,
  output logic [DATA_SIZE-1:0] past_pc,
  output logic                 pc_hold,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [DATA_SIZE-1:0] latched_pc;
  logic [DATA_SIZE-1:0] next_pc;
  logic                 stall;

  assign stall = |stall_req;

  always_comb begin
    next_state = RUN;
    next_pc    = pc_data + DATA_SIZE'(PC_STEP);
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (state == PEND) begin
      next_pc = latched_pc;
    end
    if (stall) begin
      if (redirect_valid || state == PEND) begin
        next_state = PEND;
      end else begin
        next_state = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      pc_data          <= RESET_VECTOR;
      past_pc          <= RESET_VECTOR;
      latched_pc       <= '0;
      pc_hold          <= 1'b0;
      redirect_pending <= 1'b0;
      stall_cycles     <= '0;
    end else begin
      state            <= next_state;
      pc_hold          <= (next_state != RUN);
      redirect_pending <= (next_state == PEND);
      if (stall) begin
        // newest redirect wins while the pipeline is frozen
        if (redirect_valid) begin
          latched_pc <= redirect_pc;
        end
        if (stall_cycles != {CNT_WIDTH{1'b1}}) begin
          stall_cycles <= stall_cycles + 1'b1;
        end
      end else begin
        past_pc      <= pc_data;
        pc_data      <= next_pc;
        latched_pc   <= '0;
        stall_cycles <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pause_pc_stall_controller.sv
// Scoreboarded random + directed bench for pause_pc_stall_controller.
// Expected outputs come from a queue-based reference model of the PC rules.
module tb_pause_pc_stall_controller;

  localparam int DW   = 32;
  localparam int NS   = 2;
  localparam int STEP = 4;
  localparam int CW   = 8;
  localparam logic [DW-1:0] RV = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic [DW-1:0] pc_data, past_pc;
  logic          pc_hold, redirect_pending;
  logic [CW-1:0] stall_cycles;

  pause_pc_stall_controller #(
    .DATA_SIZE(DW), .NUM_STALL(NS), .RESET_VECTOR(RV), .PC_STEP(STEP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_data(pc_data), .past_pc(past_pc), .pc_hold(pc_hold),
    .redirect_pending(redirect_pending), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] past;
    logic          hold;
    logic          pend;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   stim_done = 0;

  // reference model: redirects seen during a stall are queued, newest consumed
  logic [DW-1:0] m_pc, m_past;
  logic [DW-1:0] m_lat[$];
  int            m_cnt;
  logic          m_hold, m_pend;

  task automatic drive(input bit r, input logic [NS-1:0] s, input bit rv, input logic [DW-1:0] rpc);
    exp_t e;
    @(negedge clk);
    rst = r; stall_req = s; redirect_valid = rv; redirect_pc = rpc;
    if (r) begin
      m_pc = RV; m_past = RV; m_lat.delete(); m_cnt = 0; m_hold = 0; m_pend = 0;
    end else if (s != 0) begin
      if (rv) m_lat.push_back(rpc);
      m_cnt  = (m_cnt >= (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      m_hold = 1;
      m_pend = (m_lat.size() > 0);
    end else begin
      m_past = m_pc;
      if (rv)                    m_pc = rpc;
      else if (m_lat.size() > 0) m_pc = m_lat[$];
      else                       m_pc = m_pc + STEP;
      m_lat.delete(); m_cnt = 0; m_hold = 0; m_pend = 0;
    end
    e.pc = m_pc; e.past = m_past; e.hold = m_hold; e.pend = m_pend; e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // monitor: one expectation per clock, checked just after the edge it describes
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pc_data",          pc_data,                 e.pc);
        cmp("past_pc",          past_pc,                 e.past);
        cmp("pc_hold",          DW'(pc_hold),            DW'(e.hold));
        cmp("redirect_pending", DW'(redirect_pending),   DW'(e.pend));
        cmp("stall_cycles",     DW'(stall_cycles),       DW'(e.cnt));
      end
    end
  end

  initial begin
    int budget;
    rst = 1; stall_req = '0; redirect_valid = 0; redirect_pc = '0;
    m_pc = RV; m_past = RV; m_cnt = 0; m_hold = 0; m_pend = 0;

    // reset, then free-running 0,4,8,C
    drive(1, 2'b00, 0, 0);
    drive(1, 2'b11, 1, 32'h1234);          // reset dominates stall and redirect
    for (int i = 0; i < 4; i++) drive(0, 2'b00, 0, 0);
    // bus stall for 3 cycles at 0x10, then release
    for (int i = 0; i < 3; i++) drive(0, 2'b10, 0, 0);
    drive(0, 2'b00, 0, 0);
    // instruction stall, two redirects, newest wins
    drive(0, 2'b01, 1, 32'h200);
    drive(0, 2'b01, 0, 0);
    drive(0, 2'b01, 1, 32'h300);
    drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 0, 0);
    // latched 0x200 overridden by live redirect on release
    drive(0, 2'b01, 1, 32'h200);
    drive(0, 2'b00, 1, 32'h400);
    drive(0, 2'b00, 0, 0);
    // wrap past all-ones
    drive(0, 2'b00, 1, 32'hFFFF_FFF8);
    drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 0, 0);
    // counter saturation
    for (int i = 0; i < 300; i++) drive(0, 2'b11, 0, 0);
    drive(0, 2'b00, 0, 0);
    // reset while pending discards the latch
    drive(0, 2'b01, 1, 32'h200);
    drive(0, 2'b01, 0, 0);
    drive(1, 2'b01, 0, 0);
    drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit            r;
      logic [NS-1:0] s;
      bit            rv;
      logic [DW-1:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      rv  = ($urandom_range(0, 3) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(r, s, rv, rpc);
    end

    @(negedge clk);
    rst = 0; stall_req = '0; redirect_valid = 0;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    stim_done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
